// File: rtl/fifo_fwft_adapter.sv
// First-word-fall-through read stage behind fifo_async: issues rd_en, captures rd_data, and holds it in a 2-entry skid buffer.
// A strobe sampled at edge N is captured at N+1. A read is issued only when a buffer slot is reserved for it. Optional macro FWFT_WORD_CNT_EN adds word_cnt.
module fifo_fwft_adapter #(
  parameter int WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FWFT_WORD_CNT_EN
  ,
  output logic [15:0]      word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ;
  logic [2:0]       occ_plus;
  logic             cap;
  logic             pop;

  assign cap = inflight_q;
  assign pop = m_valid && m_ready;

  // Words already owned (buffered + in flight) minus the one leaving must leave room for a new read.
  assign occ_plus   = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en = rd_rst_n && !fifo_empty && (occ_plus < (3'd2 + {2'b00, pop}));
  assign inflight_d = fifo_rd_en;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (cap) state_d = S_ONE;
      S_ONE: begin
        if (cap && !pop)      state_d = S_TWO;
        else if (!cap && pop) state_d = S_EMPTY;
      end
      S_TWO:   if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    occ     = 2'd0;
    m_valid = 1'b0;
    case (state_q)
      S_ONE: begin
        occ     = 2'd1;
        m_valid = 1'b1;
      end
      S_TWO: begin
        occ     = 2'd2;
        m_valid = 1'b1;
      end
      default: begin
        occ     = 2'd0;
        m_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      S_EMPTY: if (cap) head_d = fifo_rd_data;
      S_ONE: begin
        if (cap && pop) head_d = fifo_rd_data;
        else if (cap)   tail_d = fifo_rd_data;
      end
      S_TWO:   if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign m_data = head_q;

`ifdef FWFT_WORD_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (pop) word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      word_cnt_q <= 16'd0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

  // The credit rule makes a capture while full unreachable.
  assert property (@(posedge rd_clk) disable iff (!rd_rst_n) !(state_q == S_TWO && cap));

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Directed bench for fifo_fwft_adapter with a behavioural registered-output FIFO read side.
module tb_fifo_fwft_adapter;

  logic       rd_clk;
  logic       rd_rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef FWFT_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif

  logic [7:0] mem [16];
  logic [4:0] wr_cnt;
  logic [4:0] rd_ptr;
  int         rd_count;

  int errors = 0;
  int checks = 0;

  fifo_fwft_adapter #(.WIDTH(8)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready)
`ifdef FWFT_WORD_CNT_EN
    ,
    .word_cnt     (word_cnt)
`endif
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Upstream FIFO read port: rd_data is registered, empty reflects words not yet read.
  assign fifo_empty = (rd_ptr >= wr_cnt);

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr       <= 5'd0;
      fifo_rd_data <= 8'd0;
      rd_count     <= 0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[3:0]];
      rd_ptr       <= rd_ptr + 5'd1;
      rd_count     <= rd_count + 1;
    end
  end

  typedef struct {
    logic       rdy;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_rd_en;
  } vec_t;

  vec_t bp_tab [22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    wr_cnt   = 5'd0;
    m_ready  = 1'b0;
    repeat (3) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_next;
    int cyc;
    logic       hold;
    logic [7:0] hold_dat;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    // Backpressure table: ready low while the buffer fills, then a full drain.
    bp_tab[0] = '{1'b0, 1'b0, 8'd0, 1'b1};
    bp_tab[1] = '{1'b0, 1'b0, 8'd0, 1'b1};
    bp_tab[2] = '{1'b0, 1'b1, 8'd0, 1'b0};
    bp_tab[3] = '{1'b0, 1'b1, 8'd0, 1'b0};
    bp_tab[4] = '{1'b0, 1'b1, 8'd0, 1'b0};
    for (int k = 5; k <= 20; k++) bp_tab[k] = '{1'b1, 1'b1, 8'(k - 5), (k <= 18)};
    bp_tab[21] = '{1'b1, 1'b0, 8'd0, 1'b0};

    // Reset held with an empty FIFO.
    rd_rst_n = 1'b0;
    wr_cnt   = 5'd0;
    m_ready  = 1'b0;
    repeat (20) begin
      @(negedge rd_clk);
      chk("reset_rd_en", 16'(fifo_rd_en), 16'd0);
      chk("reset_valid", 16'(m_valid), 16'd0);
      chk("reset_data", 16'(m_data), 16'd0);
    end
    rd_rst_n = 1'b1;
    repeat (3) begin
      @(negedge rd_clk);
      chk("idle_rd_en", 16'(fifo_rd_en), 16'd0);
      chk("idle_valid", 16'(m_valid), 16'd0);
    end

    // Full-rate stream with ready held high.
    do_reset();
    m_ready = 1'b1;
    wr_cnt  = 5'd16;
    for (int c = 0; c <= 18; c++) begin
      #1;
      chk($sformatf("stream_vld[%0d]", c), 16'(m_valid), 16'((c >= 2 && c <= 17) ? 1 : 0));
      chk($sformatf("stream_rd_en[%0d]", c), 16'(fifo_rd_en), 16'((c <= 15) ? 1 : 0));
      if (c >= 2 && c <= 17) chk($sformatf("stream_dat[%0d]", c), 16'(m_data), 16'(c - 2));
      @(negedge rd_clk);
    end
`ifdef FWFT_WORD_CNT_EN
    chk("word_cnt_16", word_cnt, 16'd16);
`endif

    // Backpressure table.
    do_reset();
    wr_cnt = 5'd16;
    for (int i = 0; i < 22; i++) begin
      m_ready = bp_tab[i].rdy;
      #1;
      chk($sformatf("bp_vld[%0d]", i), 16'(m_valid), 16'(bp_tab[i].exp_vld));
      chk($sformatf("bp_rd_en[%0d]", i), 16'(fifo_rd_en), 16'(bp_tab[i].exp_rd_en));
      if (bp_tab[i].exp_vld) chk($sformatf("bp_dat[%0d]", i), 16'(m_data), 16'(bp_tab[i].exp_dat));
      if (i == 4) chk("bp_reads_while_stalled", 16'(rd_count), 16'd2);
      @(negedge rd_clk);
    end
    chk("bp_total_reads", 16'(rd_count), 16'd16);

    // FIFO goes empty while a read is in flight.
    do_reset();
    wr_cnt = 5'd1;
    #1;
    chk("empty_c0_rd_en", 16'(fifo_rd_en), 16'd1);
    @(negedge rd_clk); #1;
    chk("empty_c1_rd_en", 16'(fifo_rd_en), 16'd0);
    chk("empty_c1_vld", 16'(m_valid), 16'd0);
    @(negedge rd_clk); #1;
    chk("empty_c2_vld", 16'(m_valid), 16'd1);
    chk("empty_c2_dat", 16'(m_data), 16'd0);
    @(negedge rd_clk); m_ready = 1'b1; #1;
    chk("empty_c3_rd_en", 16'(fifo_rd_en), 16'd0);
    chk("empty_c3_vld", 16'(m_valid), 16'd1);
    chk("empty_reads", 16'(rd_count), 16'd1);
    @(negedge rd_clk); #1;
    chk("empty_c4_vld", 16'(m_valid), 16'd0);

    // Random ready: order, completeness and stability under stall.
    do_reset();
    wr_cnt   = 5'd16;
    exp_next = 0;
    hold     = 1'b0;
    hold_dat = 8'd0;
    cyc      = 0;
    while (exp_next < 16 && cyc < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        chk("rand_hold_vld", 16'(m_valid), 16'd1);
        chk("rand_hold_dat", 16'(m_data), 16'(hold_dat));
      end
      if (m_valid && m_ready) begin
        chk($sformatf("rand_word[%0d]", exp_next), 16'(m_data), 16'(exp_next));
        exp_next++;
      end
      hold     = m_valid && !m_ready;
      hold_dat = m_data;
      @(negedge rd_clk);
      cyc++;
    end
    chk("rand_words_delivered", 16'(exp_next), 16'd16);
    #1;
    chk("rand_drained_vld", 16'(m_valid), 16'd0);
    chk("rand_total_reads", 16'(rd_count), 16'd16);

    // Asynchronous reset while the buffer is full.
    do_reset();
    wr_cnt = 5'd16;
    repeat (4) @(negedge rd_clk);
    #1;
    chk("prerst_vld", 16'(m_valid), 16'd1);
    #1;
    rd_rst_n = 1'b0;
    wr_cnt   = 5'd0;
    #1;
    chk("rst_async_vld", 16'(m_valid), 16'd0);
    chk("rst_async_rd_en", 16'(fifo_rd_en), 16'd0);
    chk("rst_async_dat", 16'(m_data), 16'd0);
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    m_ready  = 1'b1;
    repeat (3) begin
      @(negedge rd_clk); #1;
      chk("postrst_rd_en", 16'(fifo_rd_en), 16'd0);
      chk("postrst_vld", 16'(m_valid), 16'd0);
    end
    @(negedge rd_clk);
    wr_cnt = 5'd16;
    #1;
    chk("resume_rd_en", 16'(fifo_rd_en), 16'd1);
    repeat (2) @(negedge rd_clk);
    #1;
    chk("resume_vld", 16'(m_valid), 16'd1);
    chk("resume_dat", 16'(m_data), 16'd0);

`ifdef FWFT_WORD_CNT_EN
    do_reset();
    force dut.word_cnt_q = 16'hFFFF;
    #1;
    release dut.word_cnt_q;
    chk("word_cnt_forced", word_cnt, 16'hFFFF);
    m_ready = 1'b1;
    wr_cnt  = 5'd1;
    repeat (3) @(negedge rd_clk);
    #1;
    chk("word_cnt_wrap", word_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
